// File: rtl/lsu_apb_bridge.sv
// MEM-stage load/store unit: one APB transfer per request, pipeline stall while in flight.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module lsu_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trans_en,
  input  logic              mem_write,
  input  logic [1:0]        mem_strobe,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  output logic [3:0]        PSTRB,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state
);

  // APB handshake: PSEL opens SETUP for one cycle, PENABLE marks ACCESS, and the
  // transfer ends on the first ACCESS cycle with PREADY=1; fields hold until then.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_write;
  logic [1:0]          r_strobe;
  logic [2:0]          r_funct3;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                w_misaligned;
  logic                w_timeout;
  logic                w_psel;
  logic [3:0]          w_pstrb;
  logic [31:0]         w_pwdata;
  logic [31:0]         w_load;

  function automatic logic [31:0] load_extract(input logic [31:0] d,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd4:    res = {24'd0, b};
      3'd5:    res = {16'd0, h};
      default: res = d;
    endcase
    return res;
  endfunction

  assign w_misaligned = ((mem_strobe == 2'b10) && addr[0]) ||
                        ((mem_strobe == 2'b11) && (addr[1:0] != 2'b00));

`ifdef APB_TIMEOUT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state == S_SETUP)) begin
      r_cnt <= 8'd0;
    end else if ((r_state == S_ACCESS) && !PREADY) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // A PREADY arriving in the last allowed cycle still completes normally.
  assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_cnt == TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TO_LAST;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (trans_en) begin
          w_next = w_misaligned ? S_DONE : S_SETUP;
        end
      end
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: begin
        if (PREADY || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_load = load_extract(PRDATA, r_addr[1:0], r_funct3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_write  <= 1'b0;
      r_strobe <= 2'b00;
      r_funct3 <= 3'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trans_en) begin
            r_addr   <= addr;
            r_wdata  <= wdata;
            r_write  <= mem_write;
            r_strobe <= mem_strobe;
            r_funct3 <= funct3;
            r_rdata  <= 32'd0;
            r_err    <= w_misaligned;
          end
        end
        S_ACCESS: begin
          if (PREADY) begin
            r_err   <= PSLVERR;
            r_rdata <= (PSLVERR || r_write) ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pstrb  = 4'b0000;
    w_pwdata = r_wdata;
    case (r_strobe)
      2'b01: begin
        w_pstrb  = 4'b0001 << r_addr[1:0];
        w_pwdata = {4{r_wdata[7:0]}};
      end
      2'b10: begin
        w_pstrb  = 4'b0011 << {r_addr[1], 1'b0};
        w_pwdata = {2{r_wdata[15:0]}};
      end
      2'b11: begin
        w_pstrb  = 4'b1111;
        w_pwdata = r_wdata;
      end
      default: ;
    endcase
  end

  // Bus fields are forced to zero outside a transfer so an idle bus is quiet.
  assign w_psel  = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PSEL    = w_psel;
  assign PENABLE = (r_state == S_ACCESS);
  assign PWRITE  = w_psel && r_write;
  assign PADDR   = w_psel ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign PWDATA  = w_psel ? w_pwdata : 32'd0;
  assign PSTRB   = (w_psel && r_write) ? w_pstrb : 4'b0000;

  assign rvalid    = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_err;
  assign rdata     = (r_state == S_DONE) ? r_rdata : 32'd0;
  assign stall     = ((r_state == S_IDLE) && trans_en) || w_psel;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Directed bench for lsu_apb_bridge: stores, loads, wait states, errors, reset abort, timeout.
module tb_lsu_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        trans_en;
  logic        mem_write;
  logic [1:0]  mem_strobe;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  lsu_apb_bridge #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .trans_en(trans_en), .mem_write(mem_write),
    .mem_strobe(mem_strobe), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rvalid(rvalid), .err(err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: holds the request until rvalid, plays a completer with 'waits' wait states
  task automatic run_req(input string name, input logic wr, input logic [1:0] strb,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic slv, input logic [31:0] prd,
                         input int budget,
                         output logic done, output int n_stall, output int n_acc,
                         output logic saw_psel, output logic [31:0] s_paddr,
                         output logic [31:0] s_pwdata, output logic [3:0] s_pstrb,
                         output logic s_pwrite, output logic o_err);
    done = 1'b0; n_stall = 0; n_acc = 0; saw_psel = 1'b0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0; s_pwrite = 1'b0; o_err = 1'b0;
    @(negedge clk);
    mem_write = wr; mem_strobe = strb; funct3 = f3; addr = a; wdata = wd;
    PRDATA = prd; trans_en = 1'b1;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      #1;
      if (rvalid) begin
        done  = 1'b1;
        o_err = err;
        chk({name, " stall_in_done"}, {31'd0, stall}, 32'd0);
        if (exp_q.size() == 0) chk({name, " sb_underflow"}, 32'd1, 32'd0);
        else chk({name, " rdata"}, rdata, exp_q.pop_front());
      end else begin
        if (stall) n_stall++;
        if (PSEL && !PENABLE && !saw_psel) begin
          saw_psel = 1'b1; s_paddr = PADDR; s_pwdata = PWDATA;
          s_pstrb = PSTRB; s_pwrite = PWRITE;
        end
        if (PSEL && PENABLE) begin
          n_acc++;
          PREADY  = (n_acc > waits);
          PSLVERR = slv && (n_acc > waits);
        end else begin
          PREADY = 1'b0; PSLVERR = 1'b0;
        end
        @(negedge clk);
      end
    end
    trans_en = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic check_xfer(input string name, input logic wr, input logic [1:0] strb,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic slv, input logic [31:0] prd,
                            input logic [31:0] e_rdata, input logic e_err, input int e_stall,
                            input logic e_psel, input logic [31:0] e_paddr,
                            input logic [3:0] e_pstrb, input logic [31:0] e_pwdata);
    logic done, saw, s_pwrite, o_err;
    int ns, na;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0] s_pstrb;
    exp_q.push_back(e_rdata);
    run_req(name, wr, strb, f3, a, wd, waits, slv, prd, 64,
            done, ns, na, saw, s_paddr, s_pwdata, s_pstrb, s_pwrite, o_err);
    chk({name, " completed"}, {31'd0, done}, 32'd1);
    chk({name, " err"}, {31'd0, o_err}, {31'd0, e_err});
    chk({name, " stall_cycles"}, ns, e_stall);
    chk({name, " psel_seen"}, {31'd0, saw}, {31'd0, e_psel});
    if (e_psel) begin
      chk({name, " paddr"}, s_paddr, e_paddr);
      chk({name, " pstrb"}, {28'd0, s_pstrb}, {28'd0, e_pstrb});
      chk({name, " pwdata"}, s_pwdata, e_pwdata);
      chk({name, " pwrite"}, {31'd0, s_pwrite}, {31'd0, wr});
    end
  endtask

  initial begin
    logic done, saw, s_pwrite, o_err;
    int ns, na;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0] s_pstrb;

    rst = 1'b1; trans_en = 1'b0; mem_write = 1'b0; mem_strobe = 2'b00; funct3 = 3'd0;
    addr = '0; wdata = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst psel",    {31'd0, PSEL},    32'd0);
    chk("rst penable", {31'd0, PENABLE}, 32'd0);
    chk("rst pwrite",  {31'd0, PWRITE},  32'd0);
    chk("rst pstrb",   {28'd0, PSTRB},   32'd0);
    chk("rst paddr",   PADDR,            32'd0);
    chk("rst pwdata",  PWDATA,           32'd0);
    chk("rst rdata",   rdata,            32'd0);
    chk("rst rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst err",     {31'd0, err},     32'd0);
    chk("rst stall",   {31'd0, stall},   32'd0);
    chk("rst state",   {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // name, wr, strb, f3, addr, wdata, waits, slverr, prdata, exp rdata, exp err, stalls, psel, paddr, pstrb, pwdata
    check_xfer("sw", 1'b1, 2'b11, 3'd2, 32'h1000_0008, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,
               32'h0, 1'b0, 3, 1'b1, 32'h1000_0008, 4'b1111, 32'hDEAD_BEEF);
    check_xfer("sb", 1'b1, 2'b01, 3'd0, 32'h1000_0003, 32'h0000_00A5, 0, 1'b0, 32'h0,
               32'h0, 1'b0, 3, 1'b1, 32'h1000_0000, 4'b1000, 32'hA5A5_A5A5);
    check_xfer("sh", 1'b1, 2'b10, 3'd1, 32'h1000_0002, 32'h0000_1234, 1, 1'b0, 32'h0,
               32'h0, 1'b0, 4, 1'b1, 32'h1000_0000, 4'b1100, 32'h1234_1234);
    check_xfer("sb1", 1'b1, 2'b01, 3'd0, 32'h1000_0101, 32'h0000_003C, 0, 1'b0, 32'h0,
               32'h0, 1'b0, 3, 1'b1, 32'h1000_0100, 4'b0010, 32'h3C3C_3C3C);
    check_xfer("lb3", 1'b0, 2'b01, 3'd0, 32'h2000_0003, 32'h0, 0, 1'b0, 32'h80FF_7F01,
               32'hFFFF_FF80, 1'b0, 3, 1'b1, 32'h2000_0000, 4'b0000, 32'h0);
    check_xfer("lbu3", 1'b0, 2'b01, 3'd4, 32'h2000_0003, 32'h0, 0, 1'b0, 32'h80FF_7F01,
               32'h0000_0080, 1'b0, 3, 1'b1, 32'h2000_0000, 4'b0000, 32'h0);
    check_xfer("lh2", 1'b0, 2'b10, 3'd1, 32'h2000_0002, 32'h0, 0, 1'b0, 32'h80FF_7F01,
               32'hFFFF_80FF, 1'b0, 3, 1'b1, 32'h2000_0000, 4'b0000, 32'h0);
    check_xfer("lhu2", 1'b0, 2'b10, 3'd5, 32'h2000_0002, 32'h0, 0, 1'b0, 32'h80FF_7F01,
               32'h0000_80FF, 1'b0, 3, 1'b1, 32'h2000_0000, 4'b0000, 32'h0);
    check_xfer("lb1", 1'b0, 2'b01, 3'd0, 32'h2000_0005, 32'h0, 0, 1'b0, 32'h80FF_7F01,
               32'h0000_007F, 1'b0, 3, 1'b1, 32'h2000_0004, 4'b0000, 32'h0);
    check_xfer("lh0", 1'b0, 2'b10, 3'd1, 32'h2000_0000, 32'h0, 0, 1'b0, 32'h80FF_7F01,
               32'h0000_7F01, 1'b0, 3, 1'b1, 32'h2000_0000, 4'b0000, 32'h0);
    check_xfer("lw", 1'b0, 2'b11, 3'd2, 32'h2000_000C, 32'h0, 2, 1'b0, 32'h80FF_7F01,
               32'h80FF_7F01, 1'b0, 5, 1'b1, 32'h2000_000C, 4'b0000, 32'h0);
    check_xfer("f3_7_as_lw", 1'b0, 2'b11, 3'd7, 32'h2000_0010, 32'h0, 0, 1'b0, 32'hC001_D00D,
               32'hC001_D00D, 1'b0, 3, 1'b1, 32'h2000_0010, 4'b0000, 32'h0);
    check_xfer("lw_slverr", 1'b0, 2'b11, 3'd2, 32'h3000_0000, 32'h0, 5, 1'b1, 32'h1234_5678,
               32'h0, 1'b1, 8, 1'b1, 32'h3000_0000, 4'b0000, 32'h0);
    check_xfer("lw_misalign", 1'b0, 2'b11, 3'd2, 32'h3000_0001, 32'h0, 0, 1'b0, 32'h1234_5678,
               32'h0, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 32'h0);
    check_xfer("sh_misalign", 1'b1, 2'b10, 3'd1, 32'h3000_0003, 32'h0000_5555, 0, 1'b0, 32'h0,
               32'h0, 1'b1, 1, 1'b0, 32'h0, 4'b0000, 32'h0);

    // reset while in ACCESS aborts the transfer
    @(negedge clk);
    mem_write = 1'b0; mem_strobe = 2'b11; funct3 = 3'd2; addr = 32'h4000_0000; trans_en = 1'b1;
    PREADY = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("abort in_access", {31'd0, PSEL && PENABLE}, 32'd1);
    rst = 1'b1; trans_en = 1'b0;
    @(negedge clk);
    #1;
    chk("abort psel",   {31'd0, PSEL},   32'd0);
    chk("abort stall",  {31'd0, stall},  32'd0);
    chk("abort rvalid", {31'd0, rvalid}, 32'd0);
    rst = 1'b0;
    check_xfer("post_abort_lw", 1'b0, 2'b11, 3'd2, 32'h4000_0010, 32'h0, 0, 1'b0, 32'h1122_3344,
               32'h1122_3344, 1'b0, 3, 1'b1, 32'h4000_0010, 4'b0000, 32'h0);

`ifdef APB_TIMEOUT_EN
    exp_q.push_back(32'h0);
    run_req("timeout", 1'b0, 2'b11, 3'd2, 32'h5000_0000, 32'h0, 1000, 1'b0, 32'hFFFF_FFFF, 64,
            done, ns, na, saw, s_paddr, s_pwdata, s_pstrb, s_pwrite, o_err);
    chk("timeout completed",     {31'd0, done},  32'd1);
    chk("timeout access_cycles", na,             32'd4);
    chk("timeout err",           {31'd0, o_err}, 32'd1);
`else
    run_req("hang", 1'b0, 2'b11, 3'd2, 32'h5000_0000, 32'h0, 1000, 1'b0, 32'hFFFF_FFFF, 20,
            done, ns, na, saw, s_paddr, s_pwdata, s_pstrb, s_pwrite, o_err);
    #1;
    chk("hang no_completion", {31'd0, done},             32'd0);
    chk("hang stall_held",    {31'd0, stall},            32'd1);
    chk("hang still_access",  {31'd0, PSEL && PENABLE},  32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("hang reset_psel", {31'd0, PSEL}, 32'd0);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
